// File: rtl/sfp_pkg.sv
// Shared types and helpers for the signed-fixed-point vector subtractor.
package sfp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sfp_state_e;

  // Largest positive two's complement value of width w, zero-extended to 64 bits.
  function automatic logic [63:0] sfp_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value of width w; only the low w bits are meaningful.
  function automatic logic [63:0] sfp_min(input int w);
    return ~sfp_max(w);
  endfunction

endpackage

// File: rtl/sfp_sub_sat.sv
// Combinational single-element subtract with saturate (CLIP=1) or wrap (CLIP=0).
module sfp_sub_sat
  import sfp_pkg::*;
#(
  parameter int W    = 24,
  parameter int CLIP = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);

  localparam logic [W-1:0] MAXV = W'(sfp_max(W));
  localparam logic [W-1:0] MINV = W'(sfp_min(W));

  logic [W:0] w_d;

  // One guard bit: the top two bits disagree exactly when the true difference leaves W-bit range.
  assign w_d = {a[W-1], a} - {b[W-1], b};
  assign ovf = w_d[W] ^ w_d[W-1];

  if (CLIP != 0) begin : g_sat
    assign y = ovf ? (w_d[W] ? MINV : MAXV) : w_d[W-1:0];
  end else begin : g_wrap
    assign y = w_d[W-1:0];
  end

endmodule

// File: rtl/sfp_vec_sub_seq.sv
// Time-multiplexed vector subtractor: out[i] = a[i] - b[i], one element per cycle.
// Optional sticky clip flag built when SFP_VEC_SUB_STICKY_EN is defined.
module sfp_vec_sub_seq
  import sfp_pkg::*;
#(
  parameter int N    = 3,
  parameter int IW   = 8,
  parameter int FW   = 16,
  parameter int CLIP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*(IW+FW)-1:0] a,
  input  logic [N*(IW+FW)-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*(IW+FW)-1:0] out,
  output logic [N-1:0]      clipping
`ifdef SFP_VEC_SUB_STICKY_EN
  ,
  output logic              clip_sticky,
  input  logic              clip_clr
`endif
);

  localparam int W    = IW + FW;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  sfp_state_e          r_state;
  logic [IDXW-1:0]     r_idx;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [N-1:0][W-1:0] r_a;
  logic [N-1:0][W-1:0] r_b;
  logic [N-1:0][W-1:0] r_out;
  logic [N-1:0]        r_clip;

  logic [W-1:0]        w_y;
  logic                w_ovf;
  logic                w_out_hs;

  sfp_sub_sat #(.W(W), .CLIP(CLIP)) u_sub (
    .a   (r_a[r_idx]),
    .b   (r_b[r_idx]),
    .y   (w_y),
    .ovf (w_ovf)
  );

  assign w_out_hs  = r_out_valid & out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign clipping  = r_clip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_clip      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_idx      <= '0;
            r_clip     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        BUSY: begin
          r_out[r_idx]  <= w_y;
          r_clip[r_idx] <= w_ovf;
          if (r_idx == IDXW'(N - 1)) begin
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          // Result held until taken; ready is raised here so IDLE accepts on its first cycle.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_idx       <= '0;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SFP_VEC_SUB_STICKY_EN
  logic r_sticky;

  // A clip arriving on the handshake beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_out_hs) begin
      r_sticky <= (r_sticky & ~clip_clr) | (|r_clip);
    end else if (clip_clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign clip_sticky = r_sticky;
`else
  logic w_unused;
  assign w_unused = w_out_hs;
`endif

endmodule
